vscale_htif_pcr_arbiter: RTL and testbench



---
 rtl/vscale_htif_pcr_arbiter_pkg.sv | 17 +
 rtl/vscale_htif_pcr_arbiter_rr.sv | 31 +++
 rtl/vscale_htif_pcr_arbiter.sv | 120 ++++++++++++
 tb/tb_vscale_htif_pcr_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_htif_pcr_arbiter_pkg.sv
// Shared HTIF PCR constants: data width, arbiter state encodings and the timeout data word.
// Pure declarations; no logic, no latency, no flow control.
package vscale_htif_pcr_arbiter_pkg;

  localparam int HTIF_PCR_WIDTH = 64;

  localparam logic [1:0] HTIF_ARB_IDLE      = 2'd0;
  localparam logic [1:0] HTIF_ARB_ISSUE     = 2'd1;
  localparam logic [1:0] HTIF_ARB_WAIT_RESP = 2'd2;
  localparam logic [1:0] HTIF_ARB_DELIVER   = 2'd3;

  localparam logic [HTIF_PCR_WIDTH-1:0] HTIF_ARB_ERR_DATA = '1;

  localparam logic [11:0] CSR_ADDR_TO_HOST   = 12'h780;
  localparam logic [11:0] CSR_ADDR_FROM_HOST = 12'h781;

endpackage

// File: rtl/vscale_htif_pcr_arbiter_rr.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
// Zero latency; grant is one-hot or all zero when nothing is valid.
module vscale_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/vscale_htif_pcr_arbiter.sv
// Shares one HTIF PCR port among NUM_REQ requesters, one transaction in flight, round-robin.
// resp_valid rises k+2 cycles after acceptance for a k-cycle core; waiting requesters stall.
module vscale_htif_pcr_arbiter
  import vscale_htif_pcr_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = HTIF_PCR_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_rw,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          resp_err,
  output logic                          htif_pcr_req_valid,
  input  logic                          htif_pcr_req_ready,
  output logic                          htif_pcr_req_rw,
  output logic [ADDR_WIDTH-1:0]         htif_pcr_req_addr,
  output logic [DATA_WIDTH-1:0]         htif_pcr_req_data,
  input  logic                          htif_pcr_resp_valid,
  output logic                          htif_pcr_resp_ready,
  input  logic [DATA_WIDTH-1:0]         htif_pcr_resp_data,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [1:0]         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   pick;
  logic [NUM_REQ-1:0] grant;
  logic               any_valid;
  logic [CNT_W-1:0]   wd_cnt;
  logic               wd_expired;
  logic               owner_resp_ready;

  vscale_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (pick),
    .any   (any_valid)
  );

  assign req_ready           = (state == HTIF_ARB_IDLE) ? grant : '0;
  assign htif_pcr_req_valid  = (state == HTIF_ARB_ISSUE);
  assign htif_pcr_resp_ready = (state == HTIF_ARB_WAIT_RESP);
  assign busy                = (state != HTIF_ARB_IDLE);
  assign owner_resp_ready    = resp_ready[owner];

  // A zero timeout never expires; the counter then just saturates.
  assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    resp_valid = '0;
    if (state == HTIF_ARB_DELIVER) resp_valid[owner] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= HTIF_ARB_IDLE;
      rr_ptr            <= '0;
      owner             <= '0;
      htif_pcr_req_rw   <= 1'b0;
      htif_pcr_req_addr <= '0;
      htif_pcr_req_data <= '0;
      resp_data         <= '0;
      resp_err          <= 1'b0;
      wd_cnt            <= '0;
    end else begin
      case (state)
        HTIF_ARB_IDLE: begin
          if (any_valid) begin
            owner             <= pick;
            rr_ptr            <= (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
            htif_pcr_req_rw   <= req_rw[pick];
            htif_pcr_req_addr <= req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
            htif_pcr_req_data <= req_data[pick*DATA_WIDTH +: DATA_WIDTH];
            state             <= HTIF_ARB_ISSUE;
          end
        end
        HTIF_ARB_ISSUE: begin
          if (htif_pcr_req_ready) begin
            wd_cnt <= '0;
            state  <= HTIF_ARB_WAIT_RESP;
          end
        end
        HTIF_ARB_WAIT_RESP: begin
          if (htif_pcr_resp_valid) begin
            resp_data <= htif_pcr_resp_data;
            resp_err  <= 1'b0;
            state     <= HTIF_ARB_DELIVER;
          end else if (wd_expired) begin
            resp_data <= '1;
            resp_err  <= 1'b1;
            state     <= HTIF_ARB_DELIVER;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          if (owner_resp_ready) state <= HTIF_ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vscale_htif_pcr_arbiter.sv
// Scoreboard bench: expected grants, core requests and responses are queued at stimulus time
// and popped by a negedge monitor; a behavioural core answers with configurable stall/latency.
module tb_vscale_htif_pcr_arbiter;
  import vscale_htif_pcr_arbiter_pkg::*;

  typedef struct packed {
    logic        rw;
    logic [11:0] addr;
    logic [63:0] data;
  } creq_t;

  typedef struct packed {
    logic [2:0]  idx;
    logic [63:0] data;
    logic        err;
  } cresp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_ready, req_rw, resp_valid, resp_ready;
  logic [23:0]  req_addr;
  logic [127:0] req_data;
  logic [63:0]  resp_data, htif_pcr_req_data, htif_pcr_resp_data;
  logic         resp_err, htif_pcr_req_valid, htif_pcr_req_ready, htif_pcr_req_rw;
  logic [11:0]  htif_pcr_req_addr;
  logic         htif_pcr_resp_valid, htif_pcr_resp_ready, busy;

  int checks = 0;
  int errors = 0;
  int transfers = 0;
  int core_stall = 0, core_lat = 1, late_seen = 0;
  bit core_mute = 1'b0;
  logic [63:0] core_rdata = '0;
  logic late_rdy = 1'b0;

  int     exp_grant[$];
  creq_t  exp_core[$];
  cresp_t exp_resp[$];

  vscale_htif_pcr_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(12), .DATA_WIDTH(64), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .htif_pcr_req_valid(htif_pcr_req_valid), .htif_pcr_req_ready(htif_pcr_req_ready),
    .htif_pcr_req_rw(htif_pcr_req_rw), .htif_pcr_req_addr(htif_pcr_req_addr),
    .htif_pcr_req_data(htif_pcr_req_data),
    .htif_pcr_resp_valid(htif_pcr_resp_valid), .htif_pcr_resp_ready(htif_pcr_resp_ready),
    .htif_pcr_resp_data(htif_pcr_resp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/underflow expected event", nm);
  endtask

  task automatic set_req(input int idx, input logic v, input logic rw,
                         input logic [11:0] a, input logic [63:0] d);
    req_valid[idx]          = v;
    req_rw[idx]             = rw;
    req_addr[idx*12 +: 12]  = a;
    req_data[idx*64 +: 64]  = d;
  endtask

  task automatic push_txn(input int idx, input logic rw, input logic [11:0] a,
                          input logic [63:0] d, input logic [63:0] rd, input logic err,
                          input bit with_resp);
    creq_t  c;
    cresp_t r;
    c.rw = rw; c.addr = a; c.data = d;
    r.idx = 3'(idx); r.data = rd; r.err = err;
    exp_grant.push_back(idx);
    exp_core.push_back(c);
    if (with_resp) exp_resp.push_back(r);
  endtask

  // Returns at posedge+1 right after the accepting edge.
  task automatic wait_accept(input string nm);
    int n;
    bit hit;
    n = 0; hit = 1'b0;
    while (!hit && n < 300) begin
      @(negedge clk);
      n++;
      hit = |(req_valid & req_ready);
    end
    if (!hit) fail(nm);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    bit done;
    n = 0; done = 1'b0;
    while (!done && n < 300) begin
      @(posedge clk); #1;
      n++;
      done = !busy && exp_resp.size() == 0 && exp_core.size() == 0;
    end
    if (!done) fail(nm);
  endtask

  // Edges after the accepting edge until resp_valid[idx] is seen.
  task automatic resp_latency(input int idx, output int cnt);
    bit hit;
    cnt = 0; hit = 1'b0;
    while (!hit && cnt < 60) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      hit = resp_valid[idx];
    end
  endtask

  // Behavioural core: stalls req_ready, then answers core_lat cycles after the handshake.
  initial begin
    htif_pcr_req_ready  = 1'b0;
    htif_pcr_resp_valid = 1'b0;
    htif_pcr_resp_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (htif_pcr_req_valid && !reset) begin
        repeat (core_stall) begin @(posedge clk); #1; end
        htif_pcr_req_ready = 1'b1;
        @(posedge clk); #1;
        htif_pcr_req_ready = 1'b0;
        repeat (core_lat) begin @(posedge clk); #1; end
        htif_pcr_resp_valid = 1'b1;
        htif_pcr_resp_data  = core_rdata;
        if (core_mute) begin
          @(negedge clk);
          late_rdy = htif_pcr_resp_ready;
          late_seen++;
        end
        @(posedge clk); #1;
        htif_pcr_resp_valid = 1'b0;
        htif_pcr_resp_data  = '0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    int     g;
    logic [1:0] gexp;
    creq_t  c;
    cresp_t r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if ((req_valid & req_ready) != 2'b00) begin
          if (exp_grant.size() == 0) fail("grant_unexpected");
          else begin
            g = exp_grant.pop_front();
            gexp = 2'b00;
            gexp[g] = 1'b1;
            check("grant", {126'd0, req_ready}, {126'd0, gexp});
          end
        end
        if (htif_pcr_req_valid && htif_pcr_req_ready) begin
          transfers++;
          if (exp_core.size() == 0) fail("core_req_unexpected");
          else begin
            c = exp_core.pop_front();
            check("core_req", {51'd0, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data},
                  {51'd0, c});
          end
        end
        for (int i = 0; i < 2; i++) begin
          if (resp_valid[i] && resp_ready[i]) begin
            if (exp_resp.size() == 0) fail("resp_unexpected");
            else begin
              r = exp_resp.pop_front();
              check("resp", {60'd0, 3'(i), resp_data, resp_err}, {60'd0, r});
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt, xfer0, late0;
    logic [63:0] held;
    reset = 1'b1;
    req_valid = '0; req_rw = '0; req_addr = '0; req_data = '0;
    resp_ready = 2'b11;

    #2;
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_req_ready", {126'd0, req_ready}, 128'd0);
    check("rst_resp_valid", {126'd0, resp_valid}, 128'd0);
    check("rst_htif", {125'd0, htif_pcr_req_valid, htif_pcr_resp_ready, resp_err}, 128'd0);
    check("rst_resp_data", {64'd0, resp_data}, 128'd0);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // Both requesters continuously valid from reset: 0,1,0,1.
    core_lat = 1; core_rdata = 64'h77;
    push_txn(0, 1'b1, 12'h7A0, 64'hA5, 64'h77, 1'b0, 1'b1);
    push_txn(1, 1'b1, 12'h7A1, 64'h5A, 64'h77, 1'b0, 1'b1);
    push_txn(0, 1'b1, 12'h7A0, 64'hA5, 64'h77, 1'b0, 1'b1);
    push_txn(1, 1'b1, 12'h7A1, 64'h5A, 64'h77, 1'b0, 1'b1);
    set_req(0, 1'b1, 1'b1, 12'h7A0, 64'hA5);
    set_req(1, 1'b1, 1'b1, 12'h7A1, 64'h5A);
    repeat (4) wait_accept("rr_accept");
    set_req(0, 1'b0, 1'b0, 12'h0, 64'h0);
    set_req(1, 1'b0, 1'b0, 12'h0, 64'h0);
    wait_idle("rr_idle");

    // Read of tohost, core latency 3: resp_valid 5 edges after acceptance.
    core_lat = 3; core_rdata = 64'h1;
    push_txn(0, 1'b0, CSR_ADDR_TO_HOST, 64'h0, 64'h1, 1'b0, 1'b1);
    set_req(0, 1'b1, 1'b0, CSR_ADDR_TO_HOST, 64'h0);
    wait_accept("read_accept");
    set_req(0, 1'b0, 1'b0, 12'h0, 64'h0);
    resp_latency(0, cnt);
    check("read_latency", 128'(cnt), 128'd5);
    wait_idle("read_idle");

    // Core stalls req_ready for 10 cycles: fields must hold, one transfer only.
    core_stall = 10; core_lat = 1; core_rdata = 64'hDEAD_BEEF;
    xfer0 = transfers;
    push_txn(1, 1'b0, 12'h123, 64'h1234_5678_9ABC_DEF0, 64'hDEAD_BEEF, 1'b0, 1'b1);
    set_req(1, 1'b1, 1'b0, 12'h123, 64'h1234_5678_9ABC_DEF0);
    wait_accept("stall_accept");
    set_req(1, 1'b0, 1'b0, 12'h0, 64'h0);
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!(htif_pcr_req_valid && !htif_pcr_req_ready)) break;
      cnt++;
      check("issue_hold", {51'd0, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data},
            {51'd0, 1'b0, 12'h123, 64'h1234_5678_9ABC_DEF0});
    end
    check("issue_stall_cycles", 128'(cnt), 128'd10);
    wait_idle("stall_idle");
    check("issue_one_transfer", 128'(transfers - xfer0), 128'd1);
    core_stall = 0;

    // Requester 1 withholds resp_ready for 6 DELIVER cycles while requester 0 waits.
    resp_ready = 2'b01; core_lat = 2; core_rdata = 64'hC0FFEE;
    push_txn(1, 1'b1, 12'h0AB, 64'h55, 64'hC0FFEE, 1'b0, 1'b1);
    set_req(1, 1'b1, 1'b1, 12'h0AB, 64'h55);
    wait_accept("hold_accept");
    set_req(1, 1'b0, 1'b0, 12'h0, 64'h0);
    resp_latency(1, cnt);
    check("hold_first_valid", {126'd0, resp_valid}, 128'd2);
    held = resp_data;
    check("hold_first_data", {64'd0, held}, {64'd0, 64'hC0FFEE});
    @(posedge clk); #1;
    core_rdata = 64'h99;
    push_txn(0, 1'b0, 12'h0CD, 64'h66, 64'h99, 1'b0, 1'b1);
    set_req(0, 1'b1, 1'b0, 12'h0CD, 64'h66);
    for (int c = 1; c < 6; c++) begin
      @(negedge clk);
      check("hold_valid", {126'd0, resp_valid}, 128'd2);
      check("hold_data", {64'd0, resp_data}, {64'd0, held});
      check("hold_no_grant", {126'd0, req_ready}, 128'd0);
    end
    @(posedge clk); #1;
    resp_ready = 2'b11;
    wait_accept("hold_next_accept");
    set_req(0, 1'b0, 1'b0, 12'h0, 64'h0);
    wait_idle("hold_idle");

    // Silent core: error after 8 WAIT_RESP cycles, late answer in DELIVER ignored.
    core_mute = 1'b1; core_lat = 8; core_rdata = 64'h1234;
    late0 = late_seen;
    push_txn(0, 1'b0, 12'h010, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    set_req(0, 1'b1, 1'b0, 12'h010, 64'h0);
    wait_accept("wd_accept");
    set_req(0, 1'b0, 1'b0, 12'h0, 64'h0);
    resp_latency(0, cnt);
    check("wd_latency", 128'(cnt), 128'd9);
    wait_idle("wd_idle");
    check("wd_late_seen", 128'(late_seen - late0), 128'd1);
    check("wd_late_not_accepted", {127'd0, late_rdy}, 128'd0);
    core_mute = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset in WAIT_RESP drops everything; arbitration restarts at index 0.
    core_lat = 20; core_rdata = 64'hAB;
    push_txn(0, 1'b0, 12'h200, 64'h0, 64'hAB, 1'b0, 1'b0);
    set_req(0, 1'b1, 1'b0, 12'h200, 64'h0);
    wait_accept("mid_accept");
    set_req(0, 1'b0, 1'b0, 12'h0, 64'h0);
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_busy", {127'd0, busy}, 128'd0);
    check("mid_rst_valids", {124'd0, resp_valid, req_ready}, 128'd0);
    check("mid_rst_htif", {125'd0, htif_pcr_req_valid, htif_pcr_resp_ready, resp_err}, 128'd0);
    check("mid_rst_data", {52'd0, htif_pcr_req_addr, resp_data}, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    core_lat = 1; core_rdata = 64'h42;
    push_txn(0, 1'b1, 12'h300, 64'h11, 64'h42, 1'b0, 1'b1);
    push_txn(1, 1'b1, 12'h301, 64'h22, 64'h42, 1'b0, 1'b1);
    set_req(0, 1'b1, 1'b1, 12'h300, 64'h11);
    set_req(1, 1'b1, 1'b1, 12'h301, 64'h22);
    wait_accept("post_rst_accept0");
    wait_accept("post_rst_accept1");
    set_req(0, 1'b0, 1'b0, 12'h0, 64'h0);
    set_req(1, 1'b0, 1'b0, 12'h0, 64'h0);
    wait_idle("post_rst_idle");
    check("leftover_grants", 128'(exp_grant.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
